// File: rtl/fpga_awg_pkg.sv
// fpga_awg_pkg: shared constants and state types for the AWG and measurement blocks
package fpga_awg_pkg;
    localparam int DATA_W    = 14;
    localparam int MID_SCALE = 1 << (DATA_W - 1);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} meter_state_t;
    typedef enum logic {LO, HI} hs_t;
endpackage

// File: rtl/hyst_cmp.sv
// hyst_cmp: registered midscale comparator with hysteresis and rising-crossing pulse
module hyst_cmp #(
    parameter int DATA_W = 14,
    parameter int HYST   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] s_q,
    output logic              rise
);
    import fpga_awg_pkg::*;
    localparam int MID = 1 << (DATA_W - 1);
    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);
    hs_t  hs, hs_nx;
    logic above, below;
    // threshold tests on the registered sample; hs holds while inside the band
    always_comb begin
        above = s_q >= HI_TH;
        below = s_q <= LO_TH;
        hs_nx = above ? HI : below ? LO : hs;
        rise  = (hs == LO) && above;
    end
    // input sample register and comparator state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            hs  <= LO;
        end else begin
            s_q <= adc_data;
            hs  <= hs_nx;
        end
    end
endmodule

// File: rtl/adc_period_meter.sv
// adc_period_meter: period (clk cycles) and peak-to-peak measurement of ADC samples.
// Define ADC_PERIOD_METER_AVG4_EN to report the mean of four consecutive periods.
module adc_period_meter #(
    parameter int DATA_W = 14,
    parameter int HYST   = 64,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] adc_data,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vpp,
    output logic              meas_valid,
    output logic              timeout
);
    import fpga_awg_pkg::*;
    logic [DATA_W-1:0] s_q, mx, mn, mx_nx, mn_nx;
    logic              rise, cnt_full;
    logic [CNT_W-1:0]  cnt;
    meter_state_t      state, state_nx;
`ifdef ADC_PERIOD_METER_AVG4_EN
    logic [CNT_W+1:0]  sum, sum_nx;
    logic [1:0]        sub;
    logic [DATA_W-1:0] amx, amn, amx_nx, amn_nx;
`endif

    hyst_cmp #(.DATA_W(DATA_W), .HYST(HYST)) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .adc_data (adc_data),
        .s_q      (s_q),
        .rise     (rise)
    );

    // next state; a rise always wins over the counter-full timeout
    always_comb begin
        cnt_full = &cnt;
        mx_nx    = (s_q > mx) ? s_q : mx;
        mn_nx    = (s_q < mn) ? s_q : mn;
        state_nx = !en ? IDLE :
                   (state == IDLE) ? ARM :
                   rise ? MEAS :
                   (state == MEAS && cnt_full) ? ARM : state;
    end

`ifdef ADC_PERIOD_METER_AVG4_EN
    // running sum and extremes across the four periods being averaged
    always_comb begin
        sum_nx = sum + (CNT_W+2)'(cnt);
        amx_nx = (sub == 2'd0 || mx > amx) ? mx : amx;
        amn_nx = (sub == 2'd0 || mn < amn) ? mn : amn;
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // counter, extremes and reported results; pulses default low each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mx         <= '0;
            mn         <= '0;
            period     <= '0;
            vpp        <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
`ifdef ADC_PERIOD_METER_AVG4_EN
            sum        <= '0;
            sub        <= '0;
            amx        <= '0;
            amn        <= '0;
`endif
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (!en || state == IDLE) begin
                cnt <= '0;
`ifdef ADC_PERIOD_METER_AVG4_EN
                sum <= '0;
                sub <= '0;
`endif
            end else if (rise) begin
                cnt <= CNT_W'(1);
                mx  <= s_q;
                mn  <= s_q;
                if (state == MEAS) begin
`ifdef ADC_PERIOD_METER_AVG4_EN
                    if (sub == 2'd3) begin
                        period     <= sum_nx[CNT_W+1:2];
                        vpp        <= amx_nx - amn_nx;
                        meas_valid <= 1'b1;
                        sum        <= '0;
                        sub        <= '0;
                    end else begin
                        sum <= sum_nx;
                        sub <= sub + 2'd1;
                        amx <= amx_nx;
                        amn <= amn_nx;
                    end
`else
                    period     <= cnt;
                    vpp        <= mx - mn;
                    meas_valid <= 1'b1;
`endif
                end
            end else if (state == MEAS) begin
                if (cnt_full) begin
                    timeout <= 1'b1;
`ifdef ADC_PERIOD_METER_AVG4_EN
                    sum     <= '0;
                    sub     <= '0;
`endif
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    mx  <= mx_nx;
                    mn  <= mn_nx;
                end
            end
        end
    end
endmodule
